// File: rtl/jxli_fp8_nibble_tx_if.sv
// jxli_fp8_nibble_tx_if: word handshake, flush and nibble-link bundle.
// Latency: none, this file holds only wires.
// Backpressure: in_ready from the transmitter throttles in_valid.
//
// Signals: in_valid/in_ready/in_data (FP8 word push), flush (sync abort),
// tx_data/tx_en (nibble link), busy (transmitter active), tx_par (odd parity
// of tx_data, present only when JXLI_FP8TX_PARITY_EN is defined).
// master = word producer / link observer, slave = the transmitter.
interface jxli_fp8_nibble_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       flush;
  logic [3:0] tx_data;
  logic       tx_en;
  logic       busy;
`ifdef JXLI_FP8TX_PARITY_EN
  logic       tx_par;

  modport master (output in_valid, in_data, flush,
                  input  in_ready, tx_data, tx_en, busy, tx_par);
  modport slave  (input  in_valid, in_data, flush,
                  output in_ready, tx_data, tx_en, busy, tx_par);
`else
  modport master (output in_valid, in_data, flush,
                  input  in_ready, tx_data, tx_en, busy);
  modport slave  (input  in_valid, in_data, flush,
                  output in_ready, tx_data, tx_en, busy);
`endif
endinterface

// File: rtl/jxli_fp8_nibble_tx.sv
// jxli_fp8_nibble_tx: FIFO-buffered FP8 word to 4-bit nibble link serialiser, high nibble first.
// Latency: word pushed at the edge ending cycle N gives its first tx_en strobe in cycle N+2.
// Backpressure: in_ready (registered) drops while DEPTH words are queued; in_valid is ignored then.
//
// Ports: clock, reset_n (async active-low), lnk (jxli_fp8_nibble_tx_if.slave):
//   in_valid/in_ready/in_data word push, flush sync abort, tx_data/tx_en link,
//   busy status, tx_par odd parity of tx_data.
// Parameters: DEPTH (FIFO entries, power of two >= 2), GAP (idle cycles after each strobe, 0..15).
// Optional feature: define JXLI_FP8TX_PARITY_EN to add the registered tx_par output.
module jxli_fp8_nibble_tx #(
  parameter int DEPTH = 2,
  parameter int GAP   = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  jxli_fp8_nibble_tx_if.slave lnk
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         CW       = $clog2(DEPTH + 1);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_HI = 3'd1,
    GAP_HI  = 3'd2,
    SEND_LO = 3'd3,
    GAP_LO  = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [3:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          busy_q, busy_d;

  // flush discards the push of its own cycle and cancels the pop of SEND_LO
  assign push       = lnk.in_valid & in_ready_q & ~lnk.flush;
  assign pop        = (state_q == SEND_LO) & ~lnk.flush;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    count_d = count_q;
    if (lnk.flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= lnk.in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (lnk.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_nxt;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != CW'(DEPTH));
    end
  end

  // ---------------------------------------------------------------- FSM
  // Link outputs are computed for the state being entered, so a registered
  // tx_en coincides with SEND_HI / SEND_LO occupancy.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = SEND_HI;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q][7:4];
        end
      end
      SEND_HI: begin
        if (GAP > 0) begin
          state_d = GAP_HI;
          gap_d   = GAP_LOAD;
        end else begin
          state_d   = SEND_LO;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q][3:0];
        end
      end
      GAP_HI: begin
        if (gap_q == 4'd0) begin
          state_d   = SEND_LO;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q][3:0];
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      SEND_LO: begin
        if (GAP > 0) begin
          state_d = GAP_LO;
          gap_d   = GAP_LOAD;
        end else if (count_q > CW'(1)) begin
          // the head pops this edge, so the next word sits one slot on
          state_d   = SEND_HI;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_nxt][7:4];
        end else begin
          state_d = IDLE;
        end
      end
      GAP_LO: begin
        if (gap_q == 4'd0) begin
          if (count_q != '0) begin
            state_d   = SEND_HI;
            tx_en_d   = 1'b1;
            tx_data_d = mem_q[rd_ptr_q][7:4];
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lnk.flush) begin
      state_d = IDLE;
      tx_en_d = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE) || (count_d != '0);

`ifdef JXLI_FP8TX_PARITY_EN
  logic tx_par_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_q     <= 4'd0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 4'h0;
      busy_q    <= 1'b0;
`ifdef JXLI_FP8TX_PARITY_EN
      tx_par_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
`ifdef JXLI_FP8TX_PARITY_EN
      // tracks tx_data every cycle, hence valid on every strobe
      tx_par_q  <= ~^tx_data_d;
`endif
    end
  end

  assign lnk.in_ready = in_ready_q;
  assign lnk.tx_data  = tx_data_q;
  assign lnk.tx_en    = tx_en_q;
  assign lnk.busy     = busy_q;
`ifdef JXLI_FP8TX_PARITY_EN
  assign lnk.tx_par   = tx_par_q;
`endif

endmodule
